// File: rtl/collapsering_pkg.sv
// Shared types and widths for the collapsering controller.
package collapsering_pkg;

    localparam int TRIM_W = 28;
    localparam int MUX_W  = 3;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        COUNT,
        HOLD
    } state_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/collapsering_ctrl_if.sv
// Command and result handshake between a host and the collapsering controller.
interface collapsering_ctrl_if;
    import collapsering_pkg::*;

    logic             cmd_start;
    logic             cmd_busy;
    logic             result_valid;
    logic             result_ready;
    logic             result_bit;
    logic [CNT_W-1:0] result_count;
    logic             result_timeout;

    modport master (
        output cmd_start, result_ready,
        input  cmd_busy, result_valid, result_bit, result_count, result_timeout
    );

    modport slave (
        input  cmd_start, result_ready,
        output cmd_busy, result_valid, result_bit, result_count, result_timeout
    );

endinterface

// File: rtl/collapsering_sync.sv
// Brings the free-running ring output into wb_clk_i and flags each rising edge.
module collapsering_sync (
    input  logic wb_clk_i,
    input  logic wb_rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise_o = r_sync & ~r_prev;

endmodule

// File: rtl/collapsering_ctrl.sv
// Sequences one collapsering run (or Von Neumann pairs of runs) and reports the edge count.
// Define COLLAPSERING_CTRL_VONNEUMANN_EN to debias result_bit over pairs of runs.
module collapsering_ctrl
    import collapsering_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int START_CYCLES  = 2,
    parameter int QUIET_CYCLES  = 64,
    parameter int WINDOW_CYCLES = 4096
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [TRIM_W-1:0] cfg_trim_a,
    input  logic [TRIM_W-1:0] cfg_trim_b,
    input  logic [MUX_W-1:0]  cfg_clkmux,
    output logic              ring_start,
    output logic [TRIM_W-1:0] ring_trim_a,
    output logic [TRIM_W-1:0] ring_trim_b,
    output logic [MUX_W-1:0]  ring_clkmux,
    input  logic              ring_clk,
    collapsering_ctrl_if.slave bus
);

    localparam int STEP_W  = $clog2(maxOf(SETTLE_CYCLES, START_CYCLES)) + 1;
    localparam int QUIET_W = $clog2(QUIET_CYCLES) + 1;
    localparam int WIN_W   = $clog2(WINDOW_CYCLES) + 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [STEP_W-1:0]  r_step;
    logic [QUIET_W-1:0] r_quiet;
    logic [WIN_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [TRIM_W-1:0]  r_trim_a;
    logic [TRIM_W-1:0]  r_trim_b;
    logic [MUX_W-1:0]   r_clkmux;
    logic [CNT_W-1:0]   r_res_count;
    logic               r_res_bit;
    logic               r_res_timeout;
    logic               w_rise;
    logic               w_counting;
    logic               w_win_hit;
    logic               w_quiet_hit;
    logic               w_capture;
    logic               w_hold_entry;
    logic               w_timeout;
    logic               w_res_bit;
`ifdef COLLAPSERING_CTRL_VONNEUMANN_EN
    logic               r_second;
    logic               r_first_par;
    logic               w_rerun;
`endif

    collapsering_sync u_sync (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .async_i   (ring_clk),
        .rise_o    (w_rise)
    );

    assign w_capture   = (r_state == IDLE) && bus.cmd_start;
    assign w_counting  = (r_state == FIRE) || (r_state == COUNT);
    assign w_win_hit   = w_counting && (r_win == WIN_W'(WINDOW_CYCLES - 1));
    assign w_quiet_hit = (r_state == COUNT) && !w_rise && (r_quiet == QUIET_W'(QUIET_CYCLES - 1));
    // The edge seen on the cycle we leave COUNT must still land in the result.
    assign w_cnt_next  = (w_counting && w_rise && (r_edge_cnt != {CNT_W{1'b1}}))
                         ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

    always_comb begin
        w_state_next = r_state;
        w_hold_entry = 1'b0;
        w_timeout    = 1'b0;
        w_res_bit    = w_cnt_next[0];
`ifdef COLLAPSERING_CTRL_VONNEUMANN_EN
        w_rerun      = 1'b0;
`endif
        case (r_state)
            IDLE: if (bus.cmd_start) w_state_next = LOAD;
            LOAD: if (r_step == STEP_W'(SETTLE_CYCLES - 1)) w_state_next = FIRE;
            FIRE, COUNT: begin
                if (w_win_hit) begin
                    w_state_next = HOLD;
                    w_hold_entry = 1'b1;
                    w_timeout    = 1'b1;
                end else if (r_state == FIRE) begin
                    if (r_step == STEP_W'(START_CYCLES - 1)) w_state_next = COUNT;
                end else if (w_quiet_hit) begin
`ifdef COLLAPSERING_CTRL_VONNEUMANN_EN
                    if (r_second && (r_first_par != w_cnt_next[0])) begin
                        w_state_next = HOLD;
                        w_hold_entry = 1'b1;
                        w_res_bit    = r_first_par;
                    end else begin
                        w_state_next = LOAD;
                        w_rerun      = 1'b1;
                    end
`else
                    w_state_next = HOLD;
                    w_hold_entry = 1'b1;
`endif
                end
            end
            HOLD: if (bus.result_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state       <= IDLE;
            r_step        <= '0;
            r_quiet       <= '0;
            r_win         <= '0;
            r_edge_cnt    <= '0;
            r_trim_a      <= '0;
            r_trim_b      <= '0;
            r_clkmux      <= '0;
            r_res_count   <= '0;
            r_res_bit     <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_step  <= ((r_state == LOAD || r_state == FIRE) && (w_state_next == r_state))
                       ? r_step + STEP_W'(1) : '0;
            r_quiet <= ((r_state == COUNT) && !w_rise) ? r_quiet + QUIET_W'(1) : '0;
            if (r_state == LOAD)
                r_win <= '0;
            else if (w_counting)
                r_win <= r_win + WIN_W'(1);
            if (w_capture || (r_state == LOAD))
                r_edge_cnt <= '0;
            else if (w_counting)
                r_edge_cnt <= w_cnt_next;
            if (w_capture) begin
                r_trim_a <= cfg_trim_a;
                r_trim_b <= cfg_trim_b;
                r_clkmux <= cfg_clkmux;
            end
            if (w_hold_entry) begin
                r_res_count   <= w_cnt_next;
                r_res_bit     <= w_res_bit;
                r_res_timeout <= w_timeout;
            end
        end
    end

`ifdef COLLAPSERING_CTRL_VONNEUMANN_EN
    // First run of a pair stores its parity; a matching second run discards the pair.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_second    <= 1'b0;
            r_first_par <= 1'b0;
        end else if (w_capture) begin
            r_second <= 1'b0;
        end else if (w_rerun) begin
            r_second <= ~r_second;
            if (!r_second) r_first_par <= w_cnt_next[0];
        end
    end
`endif

    assign ring_start         = (r_state == FIRE);
    assign ring_trim_a        = r_trim_a;
    assign ring_trim_b        = r_trim_b;
    assign ring_clkmux        = r_clkmux;
    assign bus.cmd_busy       = (r_state != IDLE);
    assign bus.result_valid   = (r_state == HOLD);
    assign bus.result_bit     = r_res_bit;
    assign bus.result_count   = r_res_count;
    assign bus.result_timeout = r_res_timeout;

endmodule

// File: tb/tb_collapsering_ctrl.sv
// Scoreboard bench for collapsering_ctrl; define COLLAPSERING_CTRL_VONNEUMANN_EN for the paired-run build.
module tb_collapsering_ctrl;
    import collapsering_pkg::*;

    typedef struct packed {
        logic             resBit;
        logic [CNT_W-1:0] count;
        logic             timeout;
    } result_t;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic [TRIM_W-1:0] cfgTrimA;
    logic [TRIM_W-1:0] cfgTrimB;
    logic [MUX_W-1:0]  cfgClkmux;
    logic              ringClk;
    logic              ringStart;
    logic [TRIM_W-1:0] ringTrimA;
    logic [TRIM_W-1:0] ringTrimB;
    logic [MUX_W-1:0]  ringClkmux;

    result_t expQ[$];
    int      nChecks = 0;
    int      nFails = 0;
    logic    prevValid = 1'b0;

    always #5 clk = ~clk;

    collapsering_ctrl_if bus();

    collapsering_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rstN),
        .cfg_trim_a  (cfgTrimA),
        .cfg_trim_b  (cfgTrimB),
        .cfg_clkmux  (cfgClkmux),
        .ring_start  (ringStart),
        .ring_trim_a (ringTrimA),
        .ring_trim_b (ringTrimB),
        .ring_clkmux (ringClkmux),
        .ring_clk    (ringClk),
        .bus         (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] outputView();
        return {8'd0, ringStart, bus.cmd_busy, bus.result_valid, bus.result_bit,
                bus.result_timeout, |ringTrimA, |ringTrimB, |ringClkmux, bus.result_count};
    endfunction

    // Pops one expectation per rising result_valid.
    always @(negedge clk) begin
        if (rstN && bus.result_valid && !prevValid) begin
            checkOutput("scoreboard has entry", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                result_t e;
                e = expQ.pop_front();
                checkOutput("result_bit", 32'(bus.result_bit), 32'(e.resBit));
                checkOutput("result_count", 32'(bus.result_count), 32'(e.count));
                checkOutput("result_timeout", 32'(bus.result_timeout), 32'(e.timeout));
            end
        end
        prevValid = bus.result_valid;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at posedge+1; cmd_start is sampled on the next clock edge.
    task automatic applyStimulus(input logic [TRIM_W-1:0] ta, input logic [TRIM_W-1:0] tb,
                                 input logic [MUX_W-1:0] mux, input bit pushExp, input result_t e);
        cfgTrimA = ta;
        cfgTrimB = tb;
        cfgClkmux = mux;
        bus.cmd_start = 1'b1;
        if (pushExp) expQ.push_back(e);
        @(posedge clk); #1;
        bus.cmd_start = 1'b0;
        cfgTrimA = '0;
        cfgTrimB = '0;
        cfgClkmux = '0;
    endtask

    task automatic waitRingStart(input string tag);
        int n = 0;
        while (!ringStart && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(tag, 32'(ringStart), 32'd1);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!bus.result_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(tag, 32'(bus.result_valid), 32'd1);
    endtask

    task automatic sendPulses(input int n);
        for (int i = 0; i < n; i++) begin
            ringClk = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            ringClk = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
        end
    endtask

    task automatic releaseResult();
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        checkOutput("idle after release", {30'd0, bus.cmd_busy, bus.result_valid}, 32'd0);
    endtask

    task automatic testBasic();
        applyStimulus(28'h0000123, 28'h0000456, 3'd5, 1'b1, '{resBit: 1'b1, count: 16'd9, timeout: 1'b0});
        checkOutput("trim_a captured", 32'(ringTrimA), 32'h0000123);
        checkOutput("clkmux captured", 32'(ringClkmux), 32'd5);
        for (int c = 2; c <= 8; c++) begin
            checkOutput($sformatf("ring_start cycle %0d", c), 32'(ringStart), 32'((c == 6) || (c == 7)));
            @(posedge clk); #1;
        end
        sendPulses(9);
        waitValid("basic result");
        releaseResult();
    endtask

    task automatic testHoldStall();
        logic sawBusy = 1'b0;
        applyStimulus(28'hABCDEF0, 28'h5555555, 3'd2, 1'b1, '{resBit: 1'b0, count: 16'd4, timeout: 1'b0});
        waitRingStart("stall ring_start");
        sendPulses(4);
        waitValid("stall result");
        for (int c = 0; c < 20; c++) begin
            checkOutput($sformatf("hold stable %0d", c),
                        {12'd0, bus.result_valid, bus.cmd_busy, bus.result_bit, bus.result_timeout, bus.result_count},
                        {12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4});
            bus.cmd_start = (c == 5);
            @(posedge clk); #1;
        end
        bus.cmd_start = 1'b0;
        checkOutput("trim_a held", 32'(ringTrimA), 32'hABCDEF0);
        releaseResult();
        repeat (10) begin
            @(posedge clk); #1;
            sawBusy |= bus.cmd_busy;
        end
        checkOutput("hold cmd_start not queued", 32'(sawBusy), 32'd0);
    endtask

    task automatic testTimeout();
        int c = 0;
        int fireCycles = 0;
        bit started = 0;
        applyStimulus(28'h0FFFFFF, 28'h0000001, 3'd7, 1'b1, '{resBit: 1'b0, count: 16'd1024, timeout: 1'b1});
        while (!bus.result_valid && c < 6000) begin
            ringClk = c[1];
            if (ringStart) started = 1;
            if (started) fireCycles++;
            @(posedge clk); #1;
            c++;
        end
        ringClk = 1'b0;
        checkOutput("timeout reached hold", 32'(bus.result_valid), 32'd1);
        checkOutput("fire+count cycles", 32'(fireCycles), 32'd4096);
        releaseResult();
    endtask

    task automatic testResetInFire();
        applyStimulus(28'h1234567, 28'h7654321, 3'd3, 1'b0, '0);
        waitRingStart("reset run ring_start");
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async reset outputs", outputView(), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        applyStimulus(28'h0000002, 28'h0000003, 3'd1, 1'b1, '{resBit: 1'b1, count: 16'd5, timeout: 1'b0});
        checkOutput("first edge after reset", 32'(bus.cmd_busy), 32'd1);
        waitRingStart("post-reset ring_start");
        sendPulses(5);
        waitValid("post-reset result");
        releaseResult();
    endtask

    task automatic testVonNeumann();
        int vnCounts[4] = '{4, 6, 3, 8};
        int extraStarts = 0;
        int n = 0;
        applyStimulus(28'h0000077, 28'h0000088, 3'd4, 1'b1, '{resBit: 1'b1, count: 16'd8, timeout: 1'b0});
        for (int k = 0; k < 4; k++) begin
            waitRingStart($sformatf("vn run %0d start", k));
            sendPulses(vnCounts[k]);
        end
        while (!bus.result_valid && n < 300) begin
            @(posedge clk); #1;
            if (ringStart) extraStarts++;
            n++;
        end
        checkOutput("vn result after 4 runs", 32'(bus.result_valid), 32'd1);
        checkOutput("vn no fifth run", 32'(extraStarts), 32'd0);
        releaseResult();
    endtask

    initial begin
        bus.cmd_start = 1'b0;
        bus.result_ready = 1'b0;
        ringClk = 1'b0;
        cfgTrimA = '0;
        cfgTrimB = '0;
        cfgClkmux = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset state", outputView(), 32'd0);
        rstN = 1'b1;
`ifdef COLLAPSERING_CTRL_VONNEUMANN_EN
        testVonNeumann();
        testTimeout();
`else
        testBasic();
        testHoldStall();
        testTimeout();
        testResetInFire();
`endif
        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
